// File: rtl/fp_mult_sched.sv
// Purpose : round-robin scheduler sharing one combinational fp_mult among N_REQ requesters.
// Latency : handshake in cycle n -> rsp_valid in cycle n+3; one operation in flight, 4-cycle issue interval.
// Backpres: req_ready only in IDLE; RESP holds response until rsp_ready. Macro FP_MULT_SCHED_STATS_EN adds counters.
module fp_mult_sched #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    input  logic [N_REQ*3-1:0]   req_rnd,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic [2:0]           mul_rnd,
    input  logic [31:0]          mul_z,
    input  logic [7:0]           mul_status,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_z,
    output logic [7:0]           rsp_status,
    output logic [15:0]          stat_ops,
    output logic [15:0]          stat_inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] op_id;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [2:0]      op_rnd;

    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [2:0]      sel_rnd;

    // The multiplier sees the operand registers in every state, so its inputs
    // cannot move while the combinational round/exception stage settles.
    assign mul_a   = op_a;
    assign mul_b   = op_b;
    assign mul_rnd = op_rnd;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int              sum;
        logic [ID_W-1:0] idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            idx = ID_W'(sum);
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // Only the granted requester sees ready, and only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Operand slice of the granted requester.
    always_comb begin
        sel_a   = req_a[int'(grant_id)*32 +: 32];
        sel_b   = req_b[int'(grant_id)*32 +: 32];
        sel_rnd = req_rnd[int'(grant_id)*3 +: 3];
    end

    // Scheduler FSM: capture on grant, wait out the multiplier, present and hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_id      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_rnd     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_z      <= '0;
            rsp_status <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // grant_vld here is exactly the handshake of the granted requester
                    if (grant_vld) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_rnd <= sel_rnd;
                        op_id  <= grant_id;
                        rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    rsp_z      <= mul_z;
                    rsp_status <= mul_status;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FP_MULT_SCHED_STATS_EN
    logic [15:0] ops_q;
    logic [15:0] inexact_q;

    // Saturating counts of delivered responses and of those flagged inexact.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q     <= '0;
            inexact_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (ops_q != 16'hFFFF) begin
                ops_q <= ops_q + 16'd1;
            end
            if (rsp_status[5] && inexact_q != 16'hFFFF) begin
                inexact_q <= inexact_q + 16'd1;
            end
        end
    end

    assign stat_ops     = ops_q;
    assign stat_inexact = inexact_q;
`else
    assign stat_ops     = 16'd0;
    assign stat_inexact = 16'd0;
`endif

endmodule

// File: tb/tb_fp_mult_sched.sv
// Purpose : self-checking bench for fp_mult_sched with a stand-in multiplier.
// Latency : directed scenarios check exact cycle timing; random run checks against a transaction model.
// Backpres: rsp_ready is held low and randomised to exercise the response hold path.
module tb_fp_mult_sched;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*3-1:0]  req_rnd;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [2:0]      mul_rnd;
    logic [31:0]     mul_z;
    logic [7:0]      mul_status;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_z;
    logic [7:0]      rsp_status;
    logic [15:0]     stat_ops;
    logic [15:0]     stat_inexact;

    int n_pass  = 0;
    int n_total = 0;

`ifdef FP_MULT_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    fp_mult_sched #(.N_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_rnd      (req_rnd),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_rnd      (mul_rnd),
        .mul_z        (mul_z),
        .mul_status   (mul_status),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_z        (rsp_z),
        .rsp_status   (rsp_status),
        .stat_ops     (stat_ops),
        .stat_inexact (stat_inexact)
    );

    // Stand-in multiplier: two real products, otherwise a reversible scramble.
    function automatic logic [39:0] fake_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        logic [31:0] z;
        logic [7:0]  s;
        if (a == 32'h40000000 && b == 32'h40400000) begin
            z = 32'h40C00000;
            s = 8'h00;
        end else if (a == 32'h3F800000 && b == 32'h3EAAAAAB) begin
            z = 32'h3EAAAAAB;
            s = 8'h20;
        end else begin
            z = a ^ {b[15:0], b[31:16]} ^ {29'd0, r};
            s = a[7:0] ^ b[31:24] ^ {5'd0, r};
        end
        return {s, z};
    endfunction

    assign {mul_status, mul_z} = fake_mul(mul_a, mul_b, mul_rnd);

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_rnd[i*3 +: 3] = r;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        tick();
        #1;
        n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else n_pass++;
        n_total++; if (rsp_z !== 32'd0) $display("FAIL reset_rsp_z: got %h want 0", rsp_z); else n_pass++;
        n_total++; if (rsp_status !== 8'd0) $display("FAIL reset_rsp_status: got %h want 0", rsp_status); else n_pass++;
        n_total++; if (mul_a !== 32'd0 || mul_b !== 32'd0) $display("FAIL reset_mul_ab: got %h %h want 0 0", mul_a, mul_b); else n_pass++;
        n_total++; if (mul_rnd !== 3'd0) $display("FAIL reset_mul_rnd: got %0d want 0", mul_rnd); else n_pass++;
        n_total++; if (stat_ops !== 16'd0 || stat_inexact !== 16'd0) $display("FAIL reset_stats: got %0d %0d want 0 0", stat_ops, stat_inexact); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", req_ready); else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_single_op();
        do_reset();
        set_req(1, 32'h40000000, 32'h40400000, 3'd0);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        n_total++; if (req_ready !== 4'b0010) $display("FAIL single_grant: got %b want 0010", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_total++; if (rsp_valid !== (c == 3)) $display("FAIL single_valid_c%0d: got %b want %b", c, rsp_valid, (c == 3)); else n_pass++;
            if (c < 3) tick();
        end
        n_total++; if (rsp_id !== 2'd1) $display("FAIL single_id: got %0d want 1", rsp_id); else n_pass++;
        n_total++; if (rsp_z !== 32'h40C00000) $display("FAIL single_z: got %h want 40c00000", rsp_z); else n_pass++;
        n_total++; if (rsp_status !== 8'h00) $display("FAIL single_status: got %h want 00", rsp_status); else n_pass++;
        tick();
        #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL single_valid_clear: got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_fairness();
        int exp_g;
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
        req_valid = '1;
        rsp_ready = 1'b1;
        exp_g = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_rdy = '0;
            if (c % 4 == 0) begin
                exp_rdy[exp_g] = 1'b1;
                exp_g = (exp_g + 1) % N;
            end
            n_total++; if (req_ready !== exp_rdy) $display("FAIL fair_c%0d: got %b want %b", c, req_ready, exp_rdy); else n_pass++;
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, exp_z;
        logic [2:0]  r;
        logic [7:0]  exp_s;
        do_reset();
        a = $urandom; b = $urandom; r = 3'($urandom_range(0, 4));
        {exp_s, exp_z} = fake_mul(a, b, r);
        set_req(2, a, b, r);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        n_total++; if (req_ready !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", req_ready); else n_pass++;
        tick();
        req_valid = '1;
        tick();
        tick();
        for (int c = 3; c <= 7; c++) begin
            #1;
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_z !== exp_z || rsp_status !== exp_s)
                $display("FAIL bp_hold_c%0d: got v=%b id=%0d z=%h s=%h want v=1 id=2 z=%h s=%h",
                         c, rsp_valid, rsp_id, rsp_z, rsp_status, exp_z, exp_s);
            else n_pass++;
            n_total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready_c%0d: got %b want 0000", c, req_ready); else n_pass++;
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_total++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) $display("FAIL bp_release: got rdy=%b v=%b want 0000 1", req_ready, rsp_valid); else n_pass++;
        tick();
        #1;
        n_total++; if (req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b want 1000", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL bp_valid_clear: got %b want 0", rsp_valid); else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_operand_hold();
        do_reset();
        set_req(0, 32'h40000000, 32'h40400000, 3'd0);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL hold_grant: got %b want 0001", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        set_req(0, $urandom, $urandom, 3'd3);
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_total++; if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000)
                $display("FAIL hold_mul_c%0d: got %h %h want 40000000 40400000", c, mul_a, mul_b); else n_pass++;
            tick();
        end
        #1;
        n_total++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h40C00000)
            $display("FAIL hold_rsp: got v=%b z=%h want v=1 z=40c00000", rsp_valid, rsp_z); else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        set_req(3, $urandom, $urandom, 3'd1);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        n_total++; if (req_ready !== 4'b1000) $display("FAIL rsthold_grant: got %b want 1000", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = '1;
        #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rsthold_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL rsthold_ptr: got %b want 0001", req_ready); else n_pass++;
        req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            #1;
            n_total++; if (rsp_valid !== 1'b0) $display("FAIL rsthold_no_rsp_c%0d: got %b want 0", c, rsp_valid); else n_pass++;
        end
    endtask

    task automatic test_stats();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        int          tid [3];
        bit          ok;
        ta[0] = 32'h40000000; tb[0] = 32'h40400000; tid[0] = 0;
        ta[1] = 32'h3F800000; tb[1] = 32'h3EAAAAAB; tid[1] = 1;
        ta[2] = 32'h40000000; tb[2] = 32'h40400000; tid[2] = 2;
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(tid[k], ta[k], tb[k], 3'd0);
            req_valid = '0;
            req_valid[tid[k]] = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 10 && !ok; w++) begin
                #1;
                if (req_ready[tid[k]]) ok = 1'b1;
                else tick();
            end
            n_total++; if (ok !== 1'b1) $display("FAIL stats_grant_%0d: got no grant want grant", k); else n_pass++;
            tick();
            req_valid = '0;
            ok = 1'b0;
            for (int w = 0; w < 10 && !ok; w++) begin
                #1;
                if (rsp_valid) begin
                    ok = 1'b1;
                    n_total++; if (rsp_status[5] !== (k == 1)) $display("FAIL stats_inexact_flag_%0d: got %b want %b", k, rsp_status[5], (k == 1)); else n_pass++;
                end
                tick();
            end
            n_total++; if (ok !== 1'b1) $display("FAIL stats_rsp_%0d: got no response want response", k); else n_pass++;
        end
        #1;
        n_total++; if (stat_ops !== (STATS ? 16'd3 : 16'd0)) $display("FAIL stats_ops: got %0d want %0d", stat_ops, STATS ? 3 : 0); else n_pass++;
        n_total++; if (stat_inexact !== (STATS ? 16'd1 : 16'd0)) $display("FAIL stats_inexact: got %0d want %0d", stat_inexact, STATS ? 1 : 0); else n_pass++;
    endtask

    // Transaction-level model: one op in flight, round-robin choice, response 3 cycles after accept.
    task automatic test_random();
        logic [41:0]  exp_q [$];
        logic [N-1:0] taken;
        logic [N-1:0] exp_rdy;
        logic [39:0]  prod;
        logic         exp_vld;
        bit           busy;
        int           ptr, hs_cyc, g, idx, m_ops, m_inex;
        do_reset();
        taken = '0; busy = 1'b0; ptr = 0; hs_cyc = 0; m_ops = 0; m_inex = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (taken[i]) begin
                    req_valid[i] = 1'b0;
                    taken[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_req(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = '0;
            g = -1;
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            n_total++; if (req_ready !== exp_rdy) $display("FAIL rand_ready_c%0d: got %b want %b", cyc, req_ready, exp_rdy); else n_pass++;
            exp_vld = busy && (cyc >= hs_cyc + 3);
            n_total++; if (rsp_valid !== exp_vld) $display("FAIL rand_valid_c%0d: got %b want %b", cyc, rsp_valid, exp_vld); else n_pass++;
            if (exp_vld && exp_q.size() > 0) begin
                n_total++;
                if ({rsp_id, rsp_status, rsp_z} !== exp_q[0])
                    $display("FAIL rand_rsp_c%0d: got id=%0d s=%h z=%h want id=%0d s=%h z=%h",
                             cyc, rsp_id, rsp_status, rsp_z, exp_q[0][41:40], exp_q[0][39:32], exp_q[0][31:0]);
                else n_pass++;
                if (rsp_ready) begin
                    m_ops++;
                    if (exp_q[0][37]) m_inex++;
                    void'(exp_q.pop_front());
                    busy = 1'b0;
                end
            end
            if (g >= 0) begin
                prod = fake_mul(req_a[g*32 +: 32], req_b[g*32 +: 32], req_rnd[g*3 +: 3]);
                exp_q.push_back({2'(g), prod});
                ptr = (g + 1) % N;
                busy = 1'b1;
                hs_cyc = cyc;
                taken[g] = 1'b1;
            end
            tick();
        end
        #1;
        n_total++; if (stat_ops !== (STATS ? 16'(m_ops) : 16'd0)) $display("FAIL rand_stat_ops: got %0d want %0d", stat_ops, STATS ? m_ops : 0); else n_pass++;
        n_total++; if (stat_inexact !== (STATS ? 16'(m_inex) : 16'd0)) $display("FAIL rand_stat_inexact: got %0d want %0d", stat_inexact, STATS ? m_inex : 0); else n_pass++;
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_rnd   = '0;
        #2;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_operand_hold();
        test_reset_in_hold();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timeout");
    end

endmodule
